// File: rtl/slave_fifo_burst_arbiter.sv
// Bidirectional burst master for an FX2-style synchronous slave FIFO: fair read/write
// arbitration, per-grant BURST_MAX cap, RX capture with backpressure, idle/flush PKTEND.
module slave_fifo_burst_arbiter #(
   parameter int         DATA_W         = 16,
   parameter logic [1:0] RD_ADDR        = 2'b00,
   parameter logic [1:0] WR_ADDR        = 2'b10,
   parameter int         BURST_MAX      = 256,
   parameter int         CNT_W          = 9,
   parameter int         PKTEND_TIMEOUT = 64
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              FLAG_EMPTY,
   input  logic              FLAG_FULL,
   inout  wire  [DATA_W-1:0] FD,
   input  logic              tx_empty,
   input  logic [DATA_W-1:0] tx_q,
   output logic              tx_rdrq,
   input  logic              rx_full,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_wrrq,
   input  logic              flush_req,
   output logic              SLOE,
   output logic              SLRD,
   output logic              SLWR,
   output logic              PKTEND,
   output logic [1:0]        FIFOADR,
   output logic [2:0]        state_monitor
);
   localparam int               TMR_W     = $clog2(PKTEND_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] BURST_LIM = CNT_W'(BURST_MAX);
   localparam logic [TMR_W-1:0] TMR_LIM   = TMR_W'(PKTEND_TIMEOUT);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_WR_FETCH  = 3'd1,
      S_WR_STROBE = 3'd2,
      S_RD_OE     = 3'd3,
      S_RD_CHECK  = 3'd4,
      S_RD_STROBE = 3'd5,
      S_PKT_END   = 3'd6
   } state_e;

   typedef enum logic {DIR_RD = 1'b0, DIR_WR = 1'b1} dir_e;

   state_e            state_q;
   dir_e              last_dir_q;
   logic              sloe_q, slrd_q, slwr_q, pktend_q, tx_rdrq_q, rx_wrrq_q;
   logic [DATA_W-1:0] rx_data_q;
   logic [1:0]        fifoadr_q;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [TMR_W-1:0]  timer_q;
   logic              dirty_q, flush_q;
   logic              rd_ok, wr_ok, grant_rd, grant_wr;

   // On a tie the direction that did not go last wins.
   always_comb begin
      rd_ok    = !FLAG_EMPTY && !rx_full;
      wr_ok    = !tx_empty;
      grant_rd = rd_ok && (!wr_ok || last_dir_q == DIR_WR);
      grant_wr = wr_ok && !grant_rd;
      count_d  = count_q + CNT_W'(1);
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         state_q    <= S_IDLE;
         last_dir_q <= DIR_WR;
         sloe_q     <= 1'b0;
         slrd_q     <= 1'b0;
         slwr_q     <= 1'b0;
         pktend_q   <= 1'b0;
         tx_rdrq_q  <= 1'b0;
         rx_wrrq_q  <= 1'b0;
         rx_data_q  <= '0;
         fifoadr_q  <= RD_ADDR;
         count_q    <= '0;
         timer_q    <= '0;
         dirty_q    <= 1'b0;
         flush_q    <= 1'b0;
      end else begin
         // NOTE: strobes default low each cycle so every set below is a one-cycle pulse;
         // the later non-blocking assignment inside the case overrides this default.
         slrd_q    <= 1'b0;
         slwr_q    <= 1'b0;
         pktend_q  <= 1'b0;
         tx_rdrq_q <= 1'b0;
         rx_wrrq_q <= 1'b0;
         flush_q   <= flush_q | flush_req;
         case (state_q)
            S_IDLE: begin
               if (dirty_q && timer_q != TMR_LIM) timer_q <= timer_q + TMR_W'(1);
               if (grant_rd) begin
                  fifoadr_q <= RD_ADDR;
                  count_q   <= '0;
                  state_q   <= S_RD_OE;
               end else if (grant_wr) begin
                  fifoadr_q <= WR_ADDR;
                  tx_rdrq_q <= 1'b1;
                  count_q   <= '0;
                  state_q   <= S_WR_FETCH;
               end else if (dirty_q && (timer_q == TMR_LIM || flush_q)) begin
                  fifoadr_q <= WR_ADDR;
                  state_q   <= S_PKT_END;
               end else if (!dirty_q) begin
                  flush_q <= 1'b0;
               end
            end
            S_WR_FETCH: begin
               if (!FLAG_FULL) begin
                  slwr_q  <= 1'b1;
                  state_q <= S_WR_STROBE;
               end
            end
            S_WR_STROBE: begin
               count_q <= count_d;
               dirty_q <= 1'b1;
               timer_q <= '0;
               if (!tx_empty && count_d < BURST_LIM) begin
                  tx_rdrq_q <= 1'b1;
                  state_q   <= S_WR_FETCH;
               end else begin
                  last_dir_q <= DIR_WR;
                  state_q    <= S_IDLE;
               end
            end
            S_RD_OE: begin
               sloe_q  <= 1'b1;
               state_q <= S_RD_CHECK;
            end
            // Data is captured on the same edge that raises SLRD, so a word is
            // only taken when the local RX FIFO can accept it.
            S_RD_CHECK: begin
               if (!FLAG_EMPTY && !rx_full && count_q < BURST_LIM) begin
                  slrd_q    <= 1'b1;
                  rx_data_q <= FD;
                  rx_wrrq_q <= 1'b1;
                  state_q   <= S_RD_STROBE;
               end else begin
                  sloe_q     <= 1'b0;
                  last_dir_q <= DIR_RD;
                  state_q    <= S_IDLE;
               end
            end
            S_RD_STROBE: begin
               count_q <= count_d;
               state_q <= S_RD_CHECK;
            end
            S_PKT_END: begin
               pktend_q <= dirty_q;
               dirty_q  <= 1'b0;
               timer_q  <= '0;
               flush_q  <= 1'b0;
               state_q  <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign FD            = sloe_q ? {DATA_W{1'bz}} : tx_q;
   assign SLOE          = sloe_q;
   assign SLRD          = slrd_q;
   assign SLWR          = slwr_q;
   assign PKTEND        = pktend_q;
   assign tx_rdrq       = tx_rdrq_q;
   assign rx_wrrq       = rx_wrrq_q;
   assign rx_data       = rx_data_q;
   assign FIFOADR       = fifoadr_q;
   assign state_monitor = state_q;

endmodule

// File: tb/tb_slave_fifo_burst_arbiter.sv
// Bench for slave_fifo_burst_arbiter: FIFO/host environment model, transaction-level
// scoreboard checked every cycle, plus directed scenarios with literal expectations.
module tb_slave_fifo_burst_arbiter;
   localparam int         BURST_MAX      = 256;
   localparam int         PKTEND_TIMEOUT = 64;
   localparam logic [1:0] RD_ADDR        = 2'b00;
   localparam logic [1:0] WR_ADDR        = 2'b10;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n = 1'b0;
   logic        flag_full = 1'b0;
   logic        flush_req = 1'b0;
   logic        flag_empty_r = 1'b1;
   logic        tx_empty_r = 1'b1;
   logic        rx_full_r = 1'b0;
   logic [15:0] tx_q_r = '0;
   logic [15:0] host_head = '0;
   wire  [15:0] fd;
   logic        tx_rdrq, rx_wrrq, sloe, slrd, slwr, pktend;
   logic [15:0] rx_data;
   logic [1:0]  fifoadr;
   logic [2:0]  state_mon;

   // The host side drives FD only while the DUT has handed it the bus.
   assign fd = sloe ? host_head : 16'hzzzz;

   slave_fifo_burst_arbiter dut (
      .CLK(clk), .RST(rst_n), .FLAG_EMPTY(flag_empty_r), .FLAG_FULL(flag_full), .FD(fd),
      .tx_empty(tx_empty_r), .tx_q(tx_q_r), .tx_rdrq(tx_rdrq), .rx_full(rx_full_r),
      .rx_data(rx_data), .rx_wrrq(rx_wrrq), .flush_req(flush_req), .SLOE(sloe),
      .SLRD(slrd), .SLWR(slwr), .PKTEND(pktend), .FIFOADR(fifoadr), .state_monitor(state_mon)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   logic [15:0] tx_fifo_q[$];
   logic [15:0] exp_tx[$];
   logic [15:0] host_q[$];
   logic [15:0] host_in_log[$];
   logic [15:0] rx_log[$];
   bit          burst_dir[$];
   int          burst_len[$];
   int n_slwr = 0, n_rxwr = 0, n_pktend = 0;
   int cyc = 0, last_slwr_cyc = 0, pktend_cyc = 0;
   int rx_fill = 0, rx_cap = 1 << 30;
   int cur_len = 0;
   bit cur_dir = 1'b0;
   bit prev_slwr = 1'b0, prev_pktend = 1'b0, full_prev = 1'b0;

   // Compare process: scoreboard plus environment update, away from the active edge.
   always @(negedge clk) begin
      logic [15:0] w;
      cyc++;
      if (!rst_n) begin
         prev_slwr = 1'b0;
         prev_pktend = 1'b0;
         cur_len = 0;
      end else begin
         check("strobe_excl", {31'd0, slrd & slwr}, 0);
         check("sloe_state", {31'd0, sloe}, {31'd0, (state_mon == 3'd4) || (state_mon == 3'd5)});
         check("rd_align", {31'd0, rx_wrrq}, {31'd0, slrd});
         if (slwr) begin
            check("slwr_pulse", {31'd0, prev_slwr}, 0);
            check("slwr_while_full", {31'd0, full_prev}, 0);
            check("slwr_addr", {30'd0, fifoadr}, {30'd0, WR_ADDR});
            if (exp_tx.size() == 0) check("slwr_extra_word", 1, 0);
            else check("slwr_data", {16'd0, fd}, {16'd0, exp_tx.pop_front()});
            host_in_log.push_back(fd);
            n_slwr++;
            last_slwr_cyc = cyc;
            cur_dir = 1'b1;
            cur_len++;
         end
         if (slrd) begin
            check("slrd_addr", {30'd0, fifoadr}, {30'd0, RD_ADDR});
            if (host_q.size() == 0) check("slrd_on_empty", 1, 0);
            else begin
               w = host_q.pop_front();
               check("rx_data", {16'd0, rx_data}, {16'd0, w});
            end
            cur_dir = 1'b0;
            cur_len++;
         end
         if (rx_wrrq) begin
            rx_log.push_back(rx_data);
            n_rxwr++;
            rx_fill++;
         end
         if (pktend) begin
            check("pktend_pulse", {31'd0, prev_pktend}, 0);
            check("pktend_addr", {30'd0, fifoadr}, {30'd0, WR_ADDR});
            n_pktend++;
            pktend_cyc = cyc;
         end
         if (state_mon == 3'd0 && cur_len > 0) begin
            check("burst_cap", {31'd0, cur_len <= BURST_MAX}, 1);
            burst_dir.push_back(cur_dir);
            burst_len.push_back(cur_len);
            cur_len = 0;
         end
         prev_slwr = slwr;
         prev_pktend = pktend;
      end
      full_prev = flag_full;
      if (tx_rdrq && tx_fifo_q.size() > 0) tx_q_r = tx_fifo_q.pop_front();
      tx_empty_r   = (tx_fifo_q.size() == 0);
      flag_empty_r = (host_q.size() == 0);
      host_head    = (host_q.size() == 0) ? 16'h0000 : host_q[0];
      rx_full_r    = (rx_fill >= rx_cap);
   end

   task automatic settle();
      @(posedge clk);
      #1;
   endtask

   function automatic int cur_val(input int sel);
      case (sel)
         0:       return n_slwr;
         1:       return n_rxwr;
         2:       return n_pktend;
         default: return (state_mon == 3'd1) ? 1 : 0;
      endcase
   endfunction

   task automatic wait_for(input string name, input int sel, input int target, input int budget);
      bit ok = 1'b0;
      for (int k = 0; k < budget; k++) begin
         settle();
         if (cur_val(sel) >= target) begin
            ok = 1'b1;
            break;
         end
      end
      check(name, {31'd0, ok}, 1);
   endtask

   task automatic push_tx(input logic [15:0] w);
      tx_fifo_q.push_back(w);
      exp_tx.push_back(w);
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_state"}, {29'd0, state_mon}, 0);
      check({tag, "_sloe"}, {31'd0, sloe}, 0);
      check({tag, "_slrd"}, {31'd0, slrd}, 0);
      check({tag, "_slwr"}, {31'd0, slwr}, 0);
      check({tag, "_pktend"}, {31'd0, pktend}, 0);
      check({tag, "_tx_rdrq"}, {31'd0, tx_rdrq}, 0);
      check({tag, "_rx_wrrq"}, {31'd0, rx_wrrq}, 0);
      check({tag, "_fifoadr"}, {30'd0, fifoadr}, {30'd0, RD_ADDR});
      check({tag, "_fd_driven"}, {16'd0, fd}, {16'd0, tx_q_r});
   endtask

   initial begin
      int base_w, base_r, base_p, base_l;
      int s;

      // Reset state.
      repeat (3) settle();
      check_idle_outputs("rst");
      check("rst_rx_data", {16'd0, rx_data}, 0);
      rst_n = 1'b1;

      // Three writes, then auto PKTEND: 64 counting IDLE cycles, one IDLE cycle that sees
      // the saturated timer, PKT_END, then the pulse -> 67 cycles after the last SLWR.
      push_tx(16'h1111); push_tx(16'h2222); push_tx(16'h3333);
      wait_for("t1_writes", 0, 3, 60);
      check("t1_w0", {16'd0, host_in_log[0]}, 32'h1111);
      check("t1_w1", {16'd0, host_in_log[1]}, 32'h2222);
      check("t1_w2", {16'd0, host_in_log[2]}, 32'h3333);
      wait_for("t1_pktend", 2, 1, 200);
      check("t1_pktend_delay", pktend_cyc - last_slwr_cyc, PKTEND_TIMEOUT + 3);
      repeat (100) settle();
      check("t1_single_pktend", n_pktend, 1);

      // FLAG_FULL stall for 5 cycles inside a 4-word write burst.
      base_w = n_slwr; base_l = host_in_log.size(); base_p = n_pktend;
      for (int i = 0; i < 4; i++) push_tx(16'(16'hA001 + i));
      wait_for("t2_first", 0, base_w + 1, 40);
      flag_full = 1'b1;
      s = n_slwr;
      repeat (5) settle();
      check("t2_stall_state", {29'd0, state_mon}, 1);
      check("t2_no_slwr_full", n_slwr, s);
      flag_full = 1'b0;
      wait_for("t2_all", 0, base_w + 4, 40);
      for (int i = 0; i < 4; i++)
         check("t2_word", {16'd0, host_in_log[base_l + i]}, 32'hA001 + i);
      check("t2_tx_drained", exp_tx.size(), 0);
      wait_for("t2_pktend", 2, base_p + 1, 200);

      // Host offers 10 words, local RX FIFO fills after 4.
      base_r = n_rxwr; base_l = rx_log.size();
      rx_fill = 0; rx_cap = 4;
      for (int i = 0; i < 10; i++) host_q.push_back(16'(16'hB000 + i));
      wait_for("t4_four", 1, base_r + 4, 60);
      repeat (20) settle();
      check("t4_rx_count", n_rxwr - base_r, 4);
      check("t4_sloe_low", {31'd0, sloe}, 0);
      check("t4_host_left", host_q.size(), 6);
      rx_cap = 1 << 30;
      wait_for("t4_rest", 1, base_r + 10, 60);
      check("t4_r0", {16'd0, rx_log[base_l]}, 32'hB000);
      check("t4_r3", {16'd0, rx_log[base_l + 3]}, 32'hB003);
      check("t4_r4", {16'd0, rx_log[base_l + 4]}, 32'hB004);
      check("t4_r9", {16'd0, rx_log[base_l + 9]}, 32'hB009);

      // Flush after one word: SLWR(N), IDLE latches flush, IDLE acts, PKT_END, pulse at N+4.
      base_w = n_slwr; base_p = n_pktend;
      push_tx(16'hC001);
      wait_for("t5_write", 0, base_w + 1, 40);
      flush_req = 1'b1;
      settle();
      flush_req = 1'b0;
      wait_for("t5_pktend", 2, base_p + 1, 20);
      check("t5_flush_delay", pktend_cyc - last_slwr_cyc, 4);
      base_p = n_pktend;
      flush_req = 1'b1;
      settle();
      flush_req = 1'b0;
      repeat (100) settle();
      check("t5_clean_flush", n_pktend, base_p);

      // 300 words pending each way from reset: read first, then R256 W256 R44 W44.
      rst_n = 1'b0;
      settle();
      tx_fifo_q.delete(); exp_tx.delete(); host_q.delete();
      burst_dir.delete(); burst_len.delete();
      for (int i = 0; i < 300; i++) begin
         push_tx(16'(16'h5000 + i));
         host_q.push_back(16'(16'h9000 + i));
      end
      settle();
      base_r = n_rxwr; base_w = n_slwr;
      rst_n = 1'b1;
      wait_for("t3_reads", 1, base_r + 300, 3000);
      wait_for("t3_writes", 0, base_w + 300, 3000);
      repeat (5) settle();
      check("t3_bursts", burst_len.size(), 4);
      check("t3_b0_dir", {31'd0, burst_dir[0]}, 0);
      check("t3_b0_len", burst_len[0], 256);
      check("t3_b1_dir", {31'd0, burst_dir[1]}, 1);
      check("t3_b1_len", burst_len[1], 256);
      check("t3_b2_dir", {31'd0, burst_dir[2]}, 0);
      check("t3_b2_len", burst_len[2], 44);
      check("t3_b3_dir", {31'd0, burst_dir[3]}, 1);
      check("t3_b3_len", burst_len[3], 44);

      // Reset while stalled in WR_FETCH.
      base_w = n_slwr;
      flag_full = 1'b1;
      push_tx(16'hD001); push_tx(16'hD002);
      wait_for("t6_fetch", 3, 1, 40);
      rst_n = 1'b0;
      settle();
      check_idle_outputs("t6");
      tx_fifo_q.delete(); exp_tx.delete();
      flag_full = 1'b0;
      settle();
      rst_n = 1'b1;
      repeat (20) settle();
      check("t6_abandoned", n_slwr, base_w);
      check("t6_host_empty", host_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
      $fatal(1);
   end

endmodule
